mem_arbiter: RTL and testbench

- Sequences the single-ported unified RAM between the instruction-fetch requester and the data-access requester.
- Sits between the control-unit-driven datapath (iREN, dREN, dWEN, halt) and the RAM model.
- Grants one access at a time, latches the request, holds RAM signals stable until ram_ready, then returns wait/load to the winner.
- Data requests have priority over instruction requests.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
// Build option: MEM_ARB_FAIR_EN bounds how long data traffic can starve a pending fetch.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;

  logic fetch_pend;
  logic data_req;
  logic fair_force;
  logic gnt_data;
  logic gnt_inst;
  logic i_done;
  logic d_done;
  logic addr_lo_unused;

  assign fetch_pend = iREN && !halt;
  assign data_req   = dREN || dWEN;

  assign gnt_data = (state_q == IDLE) && data_req && !fair_force;
  assign gnt_inst = (state_q == IDLE) && !gnt_data && fetch_pend;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = (MAX_DSTREAK > 1) ? $clog2(MAX_DSTREAK + 1) : 1;

  logic [SW-1:0] streak_q, streak_d;

  // Once the streak limit is reached a waiting fetch wins over data.
  assign fair_force = fetch_pend && (streak_q == SW'(MAX_DSTREAK));

  always_comb begin
    streak_d = streak_q;
    if (!fetch_pend || gnt_inst) begin
      streak_d = '0;
    end else if (gnt_data && (streak_q != SW'(MAX_DSTREAK))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  localparam int dstreak_unused = MAX_DSTREAK;

  assign fair_force = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (gnt_data) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
        end else if (gnt_inst) begin
          state_d = IACC;
          addr_d  = iaddr;
          wr_d    = 1'b0;
        end
      end
      IACC, DACC: begin
        if (ram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
    end
  end

  // A requester that withdrew, or an access cut short by reset, gets no completion pulse.
  assign i_done = (state_q == IACC) && ram_ready && iREN && !RST;
  assign d_done = (state_q == DACC) && ram_ready && data_req && !RST;

  assign iwait = !i_done;
  assign dwait = !d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = (d_done && !wr_q) ? ramload : '0;

  assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign ramWEN   = (state_q == DACC) && wr_q;
  assign ramaddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign ramstore = store_q;

  assign addr_lo_unused = ^addr_q[1:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable RAM model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam byte GI = 8'h49;
  localparam byte GD = 8'h44;

  logic          CLK = 1'b0;
  logic          RST, halt, iREN, dREN, dWEN;
  logic          ram_ready = 1'b0;
  logic [AW-1:0] iaddr, daddr, ramaddr;
  logic [DW-1:0] dstore, iload, dload, ramstore;
  logic [DW-1:0] ramload = '0;
  logic          iwait, dwait, ramREN, ramWEN;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  int            ram_lat = 1;
  int            ram_cnt = 0;
  logic          force_ready = 1'b0;
  logic [DW-1:0] ram_rdata = '0;
  logic          mon_en = 1'b0;
  logic          log_en = 1'b0;
  logic          prev_strobe = 1'b0;
  byte           glog[$];
  byte           exp_seq[10];
  int            cyc;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(4)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
    #2;
  endtask

  // Samples once per cycle from the current drive point until the chosen wait drops.
  task automatic wait_done(input bit is_i, input logic [AW-1:0] exp_addr, output int cycles);
    cycles = 0;
    forever begin
      smp();
      cycles++;
      if (ramREN || ramWEN) chk("wait_ramaddr", ramaddr, exp_addr);
      if (is_i ? (iwait === 1'b0) : (dwait === 1'b0)) break;
      if (cycles >= 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_timeout: no completion after %0d cycles, expected within 50", cycles);
        break;
      end
      adv();
    end
  endtask

  always @(negedge CLK) begin
    if (ramREN || ramWEN) ram_cnt = ram_cnt + 1;
    else ram_cnt = 0;
    ram_ready = force_ready || ((ramREN || ramWEN) && (ram_cnt == ram_lat));
    ramload   = ram_rdata;
  end

  initial begin
    forever begin
      smp();
      if (mon_en) begin
        if (iwait === 1'b0) begin
          if (iq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_iwait_pulse: got iwait=0 expected 1");
          end else begin
            chk("iload", iload, iq.pop_front());
          end
        end else begin
          chk("iload_zero_while_wait", iload, 0);
        end
        if (dwait === 1'b0) begin
          if (dq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_dwait_pulse: got dwait=0 expected 1");
          end else begin
            chk("dload", dload, dq.pop_front());
          end
        end else begin
          chk("dload_zero_while_wait", dload, 0);
        end
      end
      if (log_en && (ramREN || ramWEN) && !prev_strobe)
        glog.push_back((ramaddr == 32'h100) ? GI : GD);
      prev_strobe = ramREN || ramWEN;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    smp();
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    adv();
    RST = 1'b0;
    mon_en = 1'b1;

    // Single instruction fetch, RAM ready on its third access cycle.
    ram_lat = 3; ram_rdata = 32'h3C010001; iq.push_back(32'h3C010001);
    iREN = 1'b1; iaddr = 32'h44;
    wait_done(1'b1, 32'h44, cyc);
    chk("i_grant_to_done", cyc, 4);
    adv(); iREN = 1'b0; smp();
    chk("iwait_single_cycle", iwait, 1);
    chk("idle_after_fetch", ramREN, 0);

    // Simultaneous fetch and data write: data first, one idle cycle, then fetch.
    adv();
    ram_lat = 1; iREN = 1'b1; iaddr = 32'h80;
    dWEN = 1'b1; daddr = 32'h102; dstore = 32'hDEADBEEF; dq.push_back(32'h0);
    smp();
    chk("grant_cycle_no_strobe", ramWEN, 0);
    adv(); smp();
    chk("wr_ramWEN", ramWEN, 1);
    chk("wr_ramREN", ramREN, 0);
    chk("wr_ramaddr_aligned", ramaddr, 32'h100);
    chk("wr_ramstore", ramstore, 32'hDEADBEEF);
    chk("wr_dwait", dwait, 0);
    chk("wr_iwait_pending", iwait, 1);
    adv(); dWEN = 1'b0; ram_rdata = 32'h11112222; iq.push_back(32'h11112222); smp();
    chk("gap_ramREN", ramREN, 0);
    chk("gap_ramWEN", ramWEN, 0);
    adv(); smp();
    chk("fetch_after_data_ramREN", ramREN, 1);
    chk("fetch_after_data_ramaddr", ramaddr, 32'h80);
    chk("fetch_after_data_iwait", iwait, 0);
    adv(); iREN = 1'b0;

    // Data read withdrawn mid-access with the address input changing.
    ram_lat = 3; dREN = 1'b1; daddr = 32'h300;
    smp();
    adv(); dREN = 1'b0; daddr = 32'h500; smp();
    chk("drop_ramaddr_latched", ramaddr, 32'h300);
    chk("drop_ramREN", ramREN, 1);
    adv(); smp();
    chk("drop_ramaddr_hold", ramaddr, 32'h300);
    adv(); smp();
    chk("drop_no_dwait_pulse", dwait, 1);
    adv(); smp();
    chk("drop_back_idle_ren", ramREN, 0);
    chk("drop_back_idle_wen", ramWEN, 0);

    // halt blocks fetch grants but not data; an in-flight fetch survives halt.
    adv(); halt = 1'b1; iREN = 1'b1; iaddr = 32'h180;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("halt_no_fetch", ramREN, 0);
      adv();
    end
    dREN = 1'b1; daddr = 32'h200; ram_lat = 2; ram_rdata = 32'h7; dq.push_back(32'h7);
    wait_done(1'b0, 32'h200, cyc);
    chk("d_grant_to_done", cyc, 3);
    adv(); dREN = 1'b0; smp();
    chk("halt_still_no_fetch", ramREN, 0);
    adv(); halt = 1'b0; ram_rdata = 32'h55AA00FF; iq.push_back(32'h55AA00FF); smp();
    adv(); halt = 1'b1; smp();
    chk("halt_inflight_ramREN", ramREN, 1);
    chk("halt_inflight_ramaddr", ramaddr, 32'h180);
    adv(); smp();
    chk("halt_inflight_done", iwait, 0);
    adv(); iREN = 1'b0; halt = 1'b0;

    // ram_ready while idle must not produce a completion or a grant.
    force_ready = 1'b1; smp();
    chk("idle_ready_iwait", iwait, 1);
    chk("idle_ready_dwait", dwait, 1);
    adv(); force_ready = 1'b0; smp();
    chk("idle_ready_no_ren", ramREN, 0);
    chk("idle_ready_no_wen", ramWEN, 0);

    // dREN and dWEN together behave as a write.
    adv(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678; ram_lat = 1;
    dq.push_back(32'h0);
    smp(); adv(); smp();
    chk("rw_is_write_wen", ramWEN, 1);
    chk("rw_is_write_ren", ramREN, 0);
    chk("rw_ramstore", ramstore, 32'h12345678);
    chk("rw_dwait", dwait, 0);
    adv(); dREN = 1'b0; dWEN = 1'b0;

    // Reset in the middle of a fetch abandons it silently.
    iREN = 1'b1; iaddr = 32'h60; ram_lat = 5;
    smp(); adv(); smp();
    chk("rstmid_ramREN", ramREN, 1);
    adv(); RST = 1'b1; force_ready = 1'b1; smp();
    chk("rstmid_no_pulse", iwait, 1);
    chk("rstmid_strobe_held", ramREN, 1);
    adv(); RST = 1'b0; force_ready = 1'b0; iREN = 1'b0; smp();
    chk("rstmid_strobe_dropped", ramREN, 0);
    chk("rstmid_ramaddr_cleared", ramaddr, 0);

    // Contended stream: fetch and data requests both held for ten accesses.
    adv(); ram_lat = 1; ram_rdata = 32'hCAFEF00D;
`ifdef MEM_ARB_FAIR_EN
    for (int i = 0; i < 10; i++) exp_seq[i] = ((i % 5) == 4) ? GI : GD;
    for (int i = 0; i < 8; i++) dq.push_back(32'hCAFEF00D);
    for (int i = 0; i < 2; i++) iq.push_back(32'hCAFEF00D);
`else
    for (int i = 0; i < 10; i++) exp_seq[i] = GD;
    for (int i = 0; i < 10; i++) dq.push_back(32'hCAFEF00D);
`endif
    log_en = 1'b1;
    iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200;
    for (int i = 0; i < 20; i++) begin
      smp();
      adv();
    end
    iREN = 1'b0; dREN = 1'b0;
    smp();
    log_en = 1'b0;
    chk("stream_grant_count", glog.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < glog.size()) chk($sformatf("stream_grant_%0d", i), glog[i], exp_seq[i]);
    end

    adv(); smp();
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
